// File: rtl/clk_div_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package clk_div_mon_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Divided-clock sample in, edge strobes and period/lock status out.
// No backpressure: every field is a level or a one-cycle strobe.
interface clk_div_monitor_if #(
    parameter int CNT_W = 7
);
    logic             i_clk_div;
    logic             i_clr_err;
    logic             o_rise_pulse;
    logic             o_fall_pulse;
    logic [CNT_W-1:0] o_period;
    logic [CNT_W-1:0] o_high_time;
    logic             o_meas_valid;
    logic             o_locked;
    logic             o_mismatch;
    logic             o_timeout_err;

    modport master (
        input  i_clk_div, i_clr_err,
        output o_rise_pulse, o_fall_pulse, o_period, o_high_time,
               o_meas_valid, o_locked, o_mismatch, o_timeout_err
    );

    modport slave (
        output i_clk_div, i_clr_err,
        input  o_rise_pulse, o_fall_pulse, o_period, o_high_time,
               o_meas_valid, o_locked, o_mismatch, o_timeout_err
    );
endinterface

// File: rtl/clk_edge_detect.sv
// Rise/fall detector for a signal already in the i_clk domain.
// Outputs are combinational in the edge cycle; no backpressure.
module clk_edge_detect (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;
    assign o_fall = ~i_sig & r_prev;
endmodule

// File: rtl/clk_div_monitor.sv
// Measures period/high time of a divided clock, tracks lock and stalls.
// All outputs registered, 1 cycle after the edge; no backpressure.
module clk_div_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int EXP_PERIOD = 4,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = cnt_width(TIMEOUT)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    clk_div_monitor_if.master mon
);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]   CNT_EXP    = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0]   CNT_TO     = CNT_W'(TIMEOUT);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
    localparam logic [MATCH_W-1:0] LOCK_MATCH = MATCH_W'(LOCK_COUNT);

    logic               w_rise;
    logic               w_fall;
    logic [MATCH_W-1:0] w_match_inc;

    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_hi_stage;
    state_t             r_state;
    logic [MATCH_W-1:0] r_match;
    logic               r_rise_pulse;
    logic               r_fall_pulse;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_high_time;
    logic               r_meas_vld;
    logic               r_locked;
    logic               r_mismatch;
    logic               r_timeout_err;

    state_t             nxt_state;
    logic [MATCH_W-1:0] nxt_match;
    logic [CNT_W-1:0]   nxt_period;
    logic [CNT_W-1:0]   nxt_high;
    logic               nxt_meas_vld;
    logic               nxt_locked;
    logic               nxt_mismatch;
    logic               nxt_timeout;

    clk_edge_detect u_edge (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_sig  (mon.i_clk_div),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // cnt counts cycles since the last rise; saturating keeps a dead divider visible.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_cnt      <= '0;
            r_hi_stage <= '0;
        end else begin
            if (w_rise) begin
                r_cnt <= CNT_ONE;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (w_fall) begin
                r_hi_stage <= r_cnt;
            end
        end
    end

    assign w_match_inc = r_match + MATCH_ONE;

    always_comb begin
        nxt_state    = r_state;
        nxt_match    = r_match;
        nxt_period   = r_period;
        nxt_high     = r_high_time;
        nxt_meas_vld = 1'b0;
        nxt_locked   = r_locked;
        nxt_mismatch = 1'b0;
        nxt_timeout  = r_timeout_err & ~mon.i_clr_err;

        case (r_state)
            SEARCH: begin
                nxt_match  = '0;
                nxt_locked = 1'b0;
                if (w_rise) begin
                    nxt_state = MEASURE;
                end
            end
            MEASURE, LOCKED: begin
                // A rise on the timeout cycle is a real (long) period, not a stall.
                if (w_rise) begin
                    nxt_period   = r_cnt;
                    nxt_high     = r_hi_stage;
                    nxt_meas_vld = 1'b1;
                    if (r_cnt == CNT_EXP) begin
                        if (r_state == MEASURE) begin
                            nxt_match = w_match_inc;
                            if (w_match_inc >= LOCK_MATCH) begin
                                nxt_state  = LOCKED;
                                nxt_locked = 1'b1;
                            end
                        end
                    end else begin
                        nxt_mismatch = 1'b1;
                        nxt_match    = '0;
                        nxt_locked   = 1'b0;
                        nxt_state    = MEASURE;
                    end
                end else if (r_cnt == CNT_TO) begin
                    nxt_timeout = 1'b1;
                    nxt_locked  = 1'b0;
                    nxt_match   = '0;
                    nxt_state   = SEARCH;
                end
            end
            default: begin
                nxt_state  = SEARCH;
                nxt_match  = '0;
                nxt_locked = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state       <= SEARCH;
            r_match       <= '0;
            r_rise_pulse  <= 1'b0;
            r_fall_pulse  <= 1'b0;
            r_period      <= '0;
            r_high_time   <= '0;
            r_meas_vld    <= 1'b0;
            r_locked      <= 1'b0;
            r_mismatch    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= nxt_state;
            r_match       <= nxt_match;
            r_rise_pulse  <= w_rise;
            r_fall_pulse  <= w_fall;
            r_period      <= nxt_period;
            r_high_time   <= nxt_high;
            r_meas_vld    <= nxt_meas_vld;
            r_locked      <= nxt_locked;
            r_mismatch    <= nxt_mismatch;
            r_timeout_err <= nxt_timeout;
        end
    end

    assign mon.o_rise_pulse  = r_rise_pulse;
    assign mon.o_fall_pulse  = r_fall_pulse;
    assign mon.o_period      = r_period;
    assign mon.o_high_time   = r_high_time;
    assign mon.o_meas_valid  = r_meas_vld;
    assign mon.o_locked      = r_locked;
    assign mon.o_mismatch    = r_mismatch;
    assign mon.o_timeout_err = r_timeout_err;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: directed scenarios plus random waveforms vs a cycle-index model.
module tb_clk_div_monitor;
    localparam int EXP  = 4;
    localparam int LCK  = 4;
    localparam int TO   = 64;
    localparam int CMAX = 127;

    logic i_clk = 1'b0;
    logic i_rstn;

    clk_div_monitor_if #(.CNT_W(7)) mon ();

    clk_div_monitor #(
        .EXP_PERIOD (EXP),
        .LOCK_COUNT (LCK),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .mon    (mon)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: time is a cycle index; cnt is simply "now minus last rise".
    int k = 0;
    int lr = 0;
    int hi = 0;
    bit prev_in = 0;
    bit have_ref = 0;
    int streak = 0;
    bit terr = 0;
    int e_rise, e_fall, e_period, e_high, e_mv, e_mm, e_locked, e_terr;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, k);
        end
    endtask

    task automatic model(input bit div, input bit clr, input bit rstn);
        int cnt;
        bit rise, fall;
        if (!rstn) begin
            prev_in = 0; lr = k + 1; hi = 0; have_ref = 0; streak = 0; terr = 0;
            e_rise = 0; e_fall = 0; e_period = 0; e_high = 0; e_mv = 0; e_mm = 0;
        end else begin
            cnt  = (k - lr > CMAX) ? CMAX : k - lr;
            rise = div && !prev_in;
            fall = !div && prev_in;
            e_rise = rise; e_fall = fall; e_mv = 0; e_mm = 0;
            if (clr) terr = 0;
            if (fall) hi = cnt;
            if (rise) begin
                if (have_ref) begin
                    e_period = cnt; e_high = hi; e_mv = 1;
                    if (cnt == EXP) streak++;
                    else begin streak = 0; e_mm = 1; end
                end
                have_ref = 1;
                lr = k;
            end else if (have_ref && cnt == TO) begin
                terr = 1; have_ref = 0; streak = 0;
            end
            prev_in = div;
        end
        e_locked = (have_ref && streak >= LCK) ? 1 : 0;
        e_terr = terr;
    endtask

    task automatic step(input bit div, input bit clr, input bit rstn);
        mon.i_clk_div = div;
        mon.i_clr_err = clr;
        i_rstn = rstn;
        model(div, clr, rstn);
        @(posedge i_clk);
        #1;
        chk("rise", mon.o_rise_pulse, e_rise);
        chk("fall", mon.o_fall_pulse, e_fall);
        chk("meas_valid", mon.o_meas_valid, e_mv);
        chk("period", mon.o_period, e_period);
        chk("high_time", mon.o_high_time, e_high);
        chk("mismatch", mon.o_mismatch, e_mm);
        chk("locked", mon.o_locked, e_locked);
        chk("timeout_err", mon.o_timeout_err, e_terr);
        k++;
    endtask

    task automatic run_period(input int p, input int h, input bit rnd);
        bit clr, rstn;
        for (int i = 0; i < p; i++) begin
            clr  = rnd && ($urandom_range(0, 49) == 0);
            rstn = !(rnd && ($urandom_range(0, 599) == 0));
            step(i < h, clr, rstn);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int p, h, sel, n;
        bit lvl;
        mon.i_clk_div = 0;
        mon.i_clr_err = 0;
        i_rstn = 0;
        #2;
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        chk("rst_period", mon.o_period, 0);
        chk("rst_locked", mon.o_locked, 0);

        // Lock on period 4 / high 2.
        for (int i = 0; i < 6; i++) run_period(4, 2, 0);
        chk("lock_p4", mon.o_locked, 1);

        // One stretched period breaks lock, then four good ones relock.
        run_period(6, 2, 0);
        step(1, 0, 1);
        chk("mm_pulse", mon.o_mismatch, 1);
        chk("mm_period", mon.o_period, 6);
        chk("mm_unlock", mon.o_locked, 0);
        step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
        for (int i = 0; i < 3; i++) run_period(4, 2, 0);
        chk("relock_early", mon.o_locked, 0);
        step(1, 0, 1);
        chk("relock", mon.o_locked, 1);
        step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);

        // Stall low until the timeout fires.
        for (int i = 0; i < 60; i++) step(0, 0, 1);
        chk("stall_early", mon.o_timeout_err, 0);
        step(0, 0, 1);
        chk("stall_err", mon.o_timeout_err, 1);
        chk("stall_unlock", mon.o_locked, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        chk("err_sticky", mon.o_timeout_err, 1);
        step(0, 1, 1);
        chk("clr_err", mon.o_timeout_err, 0);
        step(0, 0, 1);

        // First rise after the stall is only a reference.
        step(1, 0, 1);
        chk("search_rise", mon.o_rise_pulse, 1);
        chk("search_no_meas", mon.o_meas_valid, 0);
        step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);

        // Rise landing exactly on cnt==TIMEOUT.
        run_period(64, 10, 0);
        step(1, 0, 1);
        chk("p64_valid", mon.o_meas_valid, 1);
        chk("p64_period", mon.o_period, 64);
        chk("p64_high", mon.o_high_time, 10);
        chk("p64_mm", mon.o_mismatch, 1);
        chk("p64_no_err", mon.o_timeout_err, 0);
        step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);

        // Reset mid-lock, then relock needs 1+LOCK_COUNT rises.
        for (int i = 0; i < 6; i++) run_period(4, 2, 0);
        chk("prelock", mon.o_locked, 1);
        step(1, 0, 0);
        chk("rst2_locked", mon.o_locked, 0);
        chk("rst2_period", mon.o_period, 0);
        chk("rst2_high", mon.o_high_time, 0);
        chk("rst2_rise", mon.o_rise_pulse, 0);
        step(1, 0, 1);
        chk("rst2_ref_rise", mon.o_rise_pulse, 1);
        chk("rst2_ref_nomeas", mon.o_meas_valid, 0);
        step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
        for (int i = 0; i < 3; i++) run_period(4, 2, 0);
        chk("rst2_relock_early", mon.o_locked, 0);
        run_period(4, 2, 0);
        chk("rst2_relock", mon.o_locked, 1);

        // Random waveforms, mostly on-frequency, with stalls, clears and resets.
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 9) begin
                lvl = $urandom_range(0, 1);
                n = $urandom_range(60, 80);
                for (int j = 0; j < n; j++)
                    step(lvl, $urandom_range(0, 49) == 0, $urandom_range(0, 599) != 0);
            end else begin
                if (sel <= 5) p = EXP;
                else if (sel <= 7) p = $urandom_range(2, 8);
                else p = $urandom_range(60, 70);
                h = $urandom_range(1, p - 1);
                run_period(p, h, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Sits directly downstream of the even clock divider. Samples the divided clock as a data signal in the i_clk domain.
- Emits single-cycle rise/fall strobes for downstream logic that uses them as clock enables.
- Measures the period and high time of the divided clock in i_clk cycles.
- Declares lock once the period has matched the expected value for several consecutive periods; flags loss of lock and a stalled divider.

Parameters:
- EXP_PERIOD, 4, expected divided-clock period in i_clk cycles; must be >= 2.
- LOCK_COUNT, 4, consecutive matching periods required to assert lock; must be >= 1.
- TIMEOUT, 64, i_clk cycles without a rising edge before a stall error; must be > EXP_PERIOD.
- CNT_W, $clog2(TIMEOUT+1), derived width of the counter and the measurement outputs.

Ports:
- i_clk  input  1  clock
- i_rstn  input  1  reset: synchronous, active-low
- i_clk_div  input  1  divided clock; registered in the i_clk domain, so no synchroniser is needed
- i_clr_err  input  1  clears sticky o_timeout_err
- o_rise_pulse  output  1  one-cycle strobe per rising edge of i_clk_div
- o_fall_pulse  output  1  one-cycle strobe per falling edge of i_clk_div
- o_period  output  CNT_W  last measured period
- o_high_time  output  CNT_W  high time of the last completed period
- o_meas_valid  output  1  one-cycle strobe when o_period/o_high_time update
- o_locked  output  1  period stable at EXP_PERIOD
- o_mismatch  output  1  one-cycle strobe: a measured period was not EXP_PERIOD
- o_timeout_err  output  1  sticky stall flag

Behaviour:
- Reset: all outputs 0, state SEARCH, prev register 0, counter 0, match count 0.
- Edge detection: prev <= i_clk_div every cycle.
  - Edge cycle E for a rise: i_clk_div=1 and prev=0. Fall is the inverse condition.
  - All outputs are registered and respond in cycle E+1, so latency is 1.
- Counter cnt:
  - cnt <= 1 on a rise edge; otherwise cnt <= cnt+1, saturating at 2^CNT_W-1.
  - cnt therefore equals the number of cycles since the last rise.
- Fall edge: capture hi_stage <= cnt. o_fall_pulse is 1 in every state.
- States (encoding 2 bits):
  - SEARCH: wait for the first rise; on rise go to MEASURE. No measurement is produced and match count is 0.
  - MEASURE, on rise:
    - o_period <= cnt, o_high_time <= hi_stage, o_meas_valid pulse.
    - If cnt==EXP_PERIOD, match count++.
    - Otherwise o_mismatch pulse and match count <= 0.
    - When the incremented match count reaches LOCK_COUNT, go to LOCKED and set o_locked=1.
  - LOCKED, on rise: measurement is the same as in MEASURE.
    - A mismatch sets o_locked=0, match count=0 and returns to MEASURE.
    - A match stays in LOCKED with o_locked still 1.
- Timeout: in MEASURE or LOCKED, when cnt==TIMEOUT and there is no rise this cycle:
  - set o_timeout_err=1, o_locked=0, match count=0, and go to SEARCH.
- Simultaneous rise and timeout: the rise wins and no error is raised.
- Sticky error: o_timeout_err stays set until i_clr_err=1 or reset.
  - If i_clr_err and a new timeout happen in the same cycle, set wins.
- Reset mid-operation: reset overrides everything. The first rise after reset is only a reference edge and is never measured.
- Saturation: a saturated cnt is still reported faithfully as o_period and is a mismatch.
- Rise/fall pulses in SEARCH: o_rise_pulse also fires in SEARCH.

Decomposition:
- Package clk_div_mon_pkg:
  - state enum (SEARCH=0, MEASURE=1, LOCKED=2)
  - counter width helper function
- Sub-module clk_edge_detect: prev flop plus rise/fall combinational outputs, reused by other clock-enable consumers. The top holds the counter, FSM and output registers.

Test Plan:
- Stimulus: i_clk_div with period 4, high 2, from reset. Required response:
  - first o_meas_valid one cycle after the 2nd rise, with o_period=4 and o_high_time=2;
  - o_locked=1 one cycle after the 5th rise.
- Stimulus: once locked, insert a single period of 6 (high 2). Required response:
  - o_mismatch pulse with o_period=6;
  - o_locked falls the same cycle;
  - relock after 4 further period-4 periods.
- Stimulus: hold i_clk_div low after lock. Required response:
  - o_timeout_err=1 and o_locked=0 in the cycle after cnt reaches 64;
  - state returns to SEARCH, and the next rise produces no o_meas_valid.
- Stimulus: assert i_clr_err while stalled, with no new timeout. Required response: o_timeout_err=0 next cycle.
- Stimulus: time a rise to land on the same cycle cnt==TIMEOUT (period 64). Required response:
  - no error;
  - o_period=64 reported as a mismatch.
- Stimulus: assert i_rstn=0 for one cycle mid-lock. Required response:
  - all outputs 0 the next cycle;
  - lock requires 1+LOCK_COUNT rises again.
